issue_scheduler: RTL
====================

# issue_scheduler

Single-issue select and functional-unit allocation controller for the out-of-order core. Each cycle it picks one ready reservation-station entry whose required functional-unit type has a free unit, binds it to a specific FU index, and tells the RS to release that entry. It tracks multi-cycle and variable-latency FU occupancy so the issue stage never sends an instruction to a busy unit. The chosen FU index becomes the `issued_fu_index` carried in the ID/IS packet.

## Interface
- `RS_SIZE`, 8: reservation-station entries; power of two.
- `NUM_FU`, 5: functional units; per-index type is given by package constant `FU_TYPE_MAP`.
- `MULT_LAT`, 4: multiplier occupancy in cycles; must be ≥1.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rs_ready`  in  RS_SIZE  entry valid and all operands ready.
- `rs_fu_type`  in  RS_SIZE × FU_TYPE  required FU type per entry.
- `stall`  in  1  ID/IS register cannot accept this cycle.
- `squash`  in  1  mispredict flush.
- `fu_done`  in  NUM_FU  completion pulse; honoured only for FU_LS units.
- `issue_valid`  out  1  an entry is issued this cycle.
- `issue_rs_idx`  out  $clog2(RS_SIZE)  issued entry.
- `issue_fu_index`  out  $clog2(NUM_FU)  FU bound to the issued entry.
- `rs_clear`  out  RS_SIZE  one-hot; frees the issued entry.
- `fu_busy`  out  NUM_FU  registered occupancy per FU.

## Operation
- FU classes:
  - FU_ALU and FU_BR are single-cycle and never marked busy.
  - FU_MULT is non-pipelined and held busy by a down-counter.
  - FU_LS stays busy from issue until its `fu_done`.
- Candidate: entry i with `rs_ready[i]` where at least one FU of type `rs_fu_type[i]` has `fu_busy`=0.
- Select: round-robin over candidates, search starting at `rr_ptr` and wrapping at RS_SIZE-1→0.
- FU bind: the lowest-index free FU of the matching type.
- Issue occurs when a candidate exists and `stall`=0, `squash`=0, `reset`=0. Then:
  - `issue_valid`=1, `rs_clear` = onehot(`issue_rs_idx`), combinationally in the same cycle.
  - At the clock edge, `rr_ptr` ← (`issue_rs_idx`+1) mod RS_SIZE.
- Otherwise `issue_valid`=0, `rs_clear`=0, and `issue_rs_idx`/`issue_fu_index` drive 0.
- MULT counter, width $clog2(MULT_LAT+1):
  - Loads MULT_LAT-1 on issue; decrements to 0 each cycle.
  - `fu_busy` = (count≠0).
- LS busy bit: set on issue, cleared at the edge where `fu_done` is high. `fu_done` on a non-busy or non-LS FU is ignored.
- `stall`: no issue and `rr_ptr` holds. MULT counters still decrement and `fu_done` is still processed.
- `squash`: no issue that cycle. At the edge all MULT counters and LS busy bits clear; `rr_ptr` holds.
- `squash` together with `fu_done`: squash wins; the result is the same (FU freed).

## Timing
- Select/bind path is combinational from `rs_ready`/`rs_fu_type` and registered `fu_busy`. There is zero-cycle issue latency.
- MULT issued in cycle t: `fu_busy` is high in t+1..t+MULT_LAT-1, and the unit can reissue in t+MULT_LAT. With MULT_LAT=1 it can reissue in t+1.
- LS with `fu_done` high in cycle d: the unit is free from d+1 (no same-cycle bypass).
- Reset (async, mid-operation included):
  - `rr_ptr`=0, all counters and busy bits 0, `fu_busy`=0.
  - Combinational outputs are forced to 0 while `reset` is high.

## Structure
- Shared package `sys_defs`: `FU_TYPE` enum (FU_ALU, FU_MULT, FU_LS, FU_BR), `NUM_FU`, `FU_TYPE_MAP`, `MULT_LAT`. Default map: 0,1 ALU; 2 MULT; 3 LS; 4 BR.
- Sub-module `rr_select`: a parameterised round-robin picker, request vector + pointer → grant one-hot + index + valid. It is reused later by the CDB arbiter.

## Test plan
- Reset with the MULT counter at 2 and LS busy: `fu_busy`=0 and `issue_valid`=0 during reset. After release, entry 0 (ALU) ready → issues on FU 0.
- Entries 0 and 1 are ALU-ready, RS drops each entry the cycle after its `rs_clear`: entry 0 issues on FU 0 in cycle t, entry 1 on FU 0 in cycle t+1.
- Entry 2 MULT issues in t; entry 5 MULT is ready from t+1: `fu_busy[2]` is high t+1..t+3, and entry 5 issues in t+4.
- LS issued in t, `fu_done[3]` in t+6, second LS ready throughout: the second LS issues in t+7.
- `rr_ptr`=6, entries 1 and 7 ALU-ready: entry 7 issues first, then entry 1.
- MULT busy (count 3) and `squash` pulsed with a MULT entry ready: no issue that cycle, MULT issues in the next cycle. Separately, `stall` high for 3 cycles with a MULT in flight: no issue and `rr_ptr` unchanged, but the counter still reaches 0 on schedule.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared core definitions: functional-unit classes, the FU population and
// the per-index FU type map used by the issue stage.
package sys_defs;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_LS   = 2'd2,
    FU_BR   = 2'd3
  } FU_TYPE;

  localparam int NUM_FU   = 5;
  localparam int MULT_LAT = 4;

  // Two bits per FU index, index 0 in the low bits: 0,1 ALU; 2 MULT; 3 LS; 4 BR.
  localparam logic [2*NUM_FU-1:0] FU_TYPE_MAP = {FU_BR, FU_LS, FU_MULT, FU_ALU, FU_ALU};

  function automatic FU_TYPE fu_type_of(input int f);
    return FU_TYPE'(FU_TYPE_MAP[2*f +: 2]);
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Reservation-station / issue-stage handshake bundle for the issue scheduler.
// master = RS/pipeline side driving requests, slave = the scheduler.
interface issue_scheduler_if #(
  parameter int RS_SIZE = 8,
  parameter int NUM_FU  = 5
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int FW = $clog2(NUM_FU);

  logic [RS_SIZE-1:0]      rs_ready;
  logic [RS_SIZE-1:0][1:0] rs_fu_type;
  logic                    stall;
  logic                    squash;
  logic [NUM_FU-1:0]       fu_done;
  logic                    issue_valid;
  logic [IW-1:0]           issue_rs_idx;
  logic [FW-1:0]           issue_fu_index;
  logic [RS_SIZE-1:0]      rs_clear;
  logic [NUM_FU-1:0]       fu_busy;

  modport master (
    output rs_ready, rs_fu_type, stall, squash, fu_done,
    input  issue_valid, issue_rs_idx, issue_fu_index, rs_clear, fu_busy
  );

  modport slave (
    input  rs_ready, rs_fu_type, stall, squash, fu_done,
    output issue_valid, issue_rs_idx, issue_fu_index, rs_clear, fu_busy
  );
endinterface

// File: rtl/issue_scheduler_rr_select.sv
// Round-robin picker: scans the request vector starting at ptr, wrapping
// from N-1 to 0, and grants the first request found. N must be a power of
// two so the scan index wraps by truncation.
module rr_select #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // First requester at or after ptr in circular order
  always_comb begin : pick
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = ptr + IW'(k);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue select and FU allocation. Picks one ready RS entry per cycle
// (round-robin) whose FU class has a free unit, binds it to the lowest free
// unit of that class and frees the RS entry. Tracks MULT occupancy with a
// down-counter and LS occupancy with a busy bit released by fu_done.
module issue_scheduler #(
  parameter int RS_SIZE  = 8,
  parameter int NUM_FU   = sys_defs::NUM_FU,
  parameter int MULT_LAT = sys_defs::MULT_LAT
) (
  input  logic            clock,
  input  logic            reset,
  issue_scheduler_if.slave bus
);
  import sys_defs::*;

  localparam int IW = $clog2(RS_SIZE);
  localparam int FW = $clog2(NUM_FU);
  localparam int CW = $clog2(MULT_LAT + 1);

  logic [IW-1:0]      rr_ptr;
  logic [NUM_FU-1:0]  busy;
  logic [NUM_FU-1:0]  ls_busy;
  logic [CW-1:0]      mult_cnt [NUM_FU];
  logic [3:0]         type_free;
  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0] grant;
  logic [IW-1:0]      sel_idx;
  logic               sel_vld;
  logic [FW-1:0]      bind_fu;
  logic               bind_ok;
  logic               issue;

  // Occupancy seen by select comes only from registered state
  always_comb begin
    busy = '0;
    for (int f = 0; f < NUM_FU; f++)
      busy[f] = ls_busy[f] | (mult_cnt[f] != '0);
  end

  // Which FU classes have at least one free unit this cycle
  always_comb begin
    type_free = '0;
    for (int f = 0; f < NUM_FU; f++)
      if (!busy[f]) type_free[fu_type_of(f)] = 1'b1;
  end

  // An entry is a candidate only if its class can accept it now
  always_comb begin
    cand = '0;
    for (int i = 0; i < RS_SIZE; i++)
      cand[i] = bus.rs_ready[i] & type_free[bus.rs_fu_type[i]];
  end

  rr_select #(.N(RS_SIZE)) u_rr_select (
    .req   (cand),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (sel_idx),
    .valid (sel_vld)
  );

  // Bind the selected entry to the lowest-index free unit of its class
  always_comb begin
    bind_fu = '0;
    bind_ok = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (!bind_ok && !busy[f] && fu_type_of(f) == FU_TYPE'(bus.rs_fu_type[sel_idx])) begin
        bind_ok = 1'b1;
        bind_fu = FW'(f);
      end
    end
  end

  assign issue = sel_vld & bind_ok & ~bus.stall & ~bus.squash & ~reset;

  assign bus.issue_valid    = issue;
  assign bus.issue_rs_idx   = issue ? sel_idx : '0;
  assign bus.issue_fu_index = issue ? bind_fu : '0;
  assign bus.rs_clear       = issue ? grant   : '0;
  assign bus.fu_busy        = busy;

  // Round-robin pointer moves just past the entry that issued
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rr_ptr <= '0;
    else if (issue) rr_ptr <= sel_idx + IW'(1);
  end

  // MULT down-counters and LS busy bits; squash drops all in-flight occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ls_busy <= '0;
      for (int f = 0; f < NUM_FU; f++) mult_cnt[f] <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (fu_type_of(f) == FU_MULT) begin
          if (bus.squash)                          mult_cnt[f] <= '0;
          else if (issue && bind_fu == FW'(f))     mult_cnt[f] <= CW'(MULT_LAT - 1);
          else if (mult_cnt[f] != '0)              mult_cnt[f] <= mult_cnt[f] - CW'(1);
        end else begin
          mult_cnt[f] <= '0;
        end
        if (fu_type_of(f) == FU_LS) begin
          if (bus.squash)                          ls_busy[f] <= 1'b0;
          else if (issue && bind_fu == FW'(f))     ls_busy[f] <= 1'b1;
          else if (bus.fu_done[f])                 ls_busy[f] <= 1'b0;
        end else begin
          ls_busy[f] <= 1'b0;
        end
      end
    end
  end

endmodule
